dmem_ctrl: RTL

- Data-memory bus controller directly downstream of the MEM stage.
- Converts the MEM stage's single-cycle memory request (ce/we/sel/addr/data) into a req/ack transaction on the external data bus.
- Asserts a pipeline stall request until the transaction completes, then returns the read word to the MEM stage for byte/halfword extraction.
- Times out hung bus cycles and flags them with an error pulse.

---
 rtl/dmem_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller sitting behind the MEM stage.
// Turns a single-cycle MEM request into a req/ack bus transaction, stalls the
// pipeline until completion, returns load data, and times out hung cycles.
//
// Handshake: the MEM side presents a request with mem_ce_i and must hold its
// inputs stable while stallreq_o=1. The bus side sees bus_req_o held high with
// stable bus_* fields until a single-cycle bus_ack_i. bus_rdata_i is sampled
// only in that ack cycle. An ack seen outside BUSY is ignored.
module dmem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       mem_data_q;
  logic              err_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [3:0]        bus_sel_q;
  logic [31:0]       bus_addr_q;
  logic [31:0]       bus_wdata_q;

  // Byte offset is carried by the lane select; the bus address is word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  logic req_valid;
  assign req_valid = mem_ce_i && (mem_sel_i != 4'b0000);

  // Control FSM with all bus/MEM outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            bus_we_q    <= mem_we_i;
            bus_sel_q   <= mem_sel_i;
            bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_q <= mem_data_i;
            bus_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= BUSY;
          end else if (mem_ce_i) begin
            // Misaligned access flagged upstream by an empty lane select.
            mem_data_q <= '0;
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            // Ack takes priority over a coincident timeout.
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              mem_data_q <= bus_rdata_i;
            end
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            bus_req_q  <= 1'b0;
            mem_data_q <= '0;
            err_q      <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is raised combinationally in the request cycle so the pipeline holds.
  always_comb begin
    stallreq_o = 1'b0;
    if (!rst) begin
      stallreq_o = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    end
  end

  assign mem_data_o  = mem_data_q;
  assign err_o       = err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign dbg_state_o = state_q;

endmodule
